// File: rtl/piso_pkg.sv
// piso_pkg: FSM state type and encodings for piso_serializer.
// PARITY exists only when SERIAL_PARITY_EN is defined.
package piso_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT
`ifdef SERIAL_PARITY_EN
    ,
    PARITY = ST_PARITY
`endif
  } state_e;

endpackage

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-load shifter, exposes the bit on the wire.
// Ports: clk, reset (async low), load, shift, din[WIDTH], cur.
module piso_shift_reg
  import piso_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             cur
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      if (MSB_FIRST != 0) begin
        q <= {q[WIDTH-2:0], 1'b0};
      end else begin
        q <= {1'b0, q[WIDTH-1:1]};
      end
    end
  end

  assign cur = (MSB_FIRST != 0) ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel-in, serial-out framer.
// Ports: clk, reset (async low), load_valid/load_data/load_ready,
// sout, sout_valid, frame_start, done. Option: SERIAL_PARITY_EN.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifndef SERIAL_PARITY_EN
  localparam logic [CW-1:0] PRE = CW'(WIDTH - 2);
`endif

  state_e        state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          cur;

  assign accept = load_valid & load_ready;

  piso_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_sr (
    .clk  (clk),
    .reset(reset),
    .load (accept),
    .shift(state == SHIFT),
    .din  (load_data),
    .cur  (cur)
  );

`ifdef SERIAL_PARITY_EN
  logic par;

  assign sout = ((state == SHIFT) & cur)
              | ((state == PARITY) & par);
`else
  assign sout = (state == SHIFT) & cur;
`endif

  // load_ready is high exactly in IDLE and in the final frame
  // cycle, so it also marks "frame over, start or go idle".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
      done        <= 1'b0;
      load_ready  <= 1'b1;
`ifdef SERIAL_PARITY_EN
      par         <= 1'b0;
`endif
    end else if (load_ready) begin
      cnt  <= '0;
      done <= 1'b0;
      if (accept) begin
        state       <= SHIFT;
        sout_valid  <= 1'b1;
        frame_start <= 1'b1;
        load_ready  <= 1'b0;
`ifdef SERIAL_PARITY_EN
        par         <= ^load_data;
`endif
      end else begin
        state       <= IDLE;
        sout_valid  <= 1'b0;
        frame_start <= 1'b0;
        load_ready  <= 1'b1;
      end
    end else begin
      frame_start <= 1'b0;
      cnt         <= cnt + 1'b1;
`ifdef SERIAL_PARITY_EN
      if (cnt == LAST) begin
        state      <= PARITY;
        done       <= 1'b1;
        load_ready <= 1'b1;
      end
`else
      done       <= (cnt == PRE);
      load_ready <= (cnt == PRE);
`endif
    end
  end

`ifndef SERIAL_PARITY_EN
  logic unused_last;
  assign unused_last = ^LAST;
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed vectors for piso_serializer, WIDTH=8.
// Follows SERIAL_PARITY_EN for the frame length.
module tb_piso_serializer;

`ifdef SERIAL_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       sel;

  logic       lv_m, lr_m, so_m, sv_m, fs_m, dn_m;
  logic [7:0] ld_m;
  logic       lv_l, lr_l, so_l, sv_l, fs_l, dn_l;
  logic [7:0] ld_l;

  logic o_rdy, o_so, o_sv, o_fs, o_dn;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  piso_serializer #(
    .WIDTH    (8),
    .MSB_FIRST(1)
  ) u_msb (
    .clk        (clk),
    .reset      (reset),
    .load_valid (lv_m),
    .load_data  (ld_m),
    .load_ready (lr_m),
    .sout       (so_m),
    .sout_valid (sv_m),
    .frame_start(fs_m),
    .done       (dn_m)
  );

  piso_serializer #(
    .WIDTH    (8),
    .MSB_FIRST(0)
  ) u_lsb (
    .clk        (clk),
    .reset      (reset),
    .load_valid (lv_l),
    .load_data  (ld_l),
    .load_ready (lr_l),
    .sout       (so_l),
    .sout_valid (sv_l),
    .frame_start(fs_l),
    .done       (dn_l)
  );

  assign o_rdy = sel ? lr_l : lr_m;
  assign o_so  = sel ? so_l : so_m;
  assign o_sv  = sel ? sv_l : sv_m;
  assign o_fs  = sel ? fs_l : fs_m;
  assign o_dn  = sel ? dn_l : dn_m;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ebit(input logic [7:0] w,
                                input int k,
                                input bit msb);
    if (k == 9) return ^w;
    return msb ? w[8-k] : w[k-1];
  endfunction

  task automatic drive(input logic v, input logic [7:0] d);
    if (sel) begin
      lv_l = v;
      ld_l = d;
    end else begin
      lv_m = v;
      ld_m = d;
    end
  endtask

  task automatic expect_cyc(input string tag,
                            input logic v, input logic b,
                            input logic f, input logic d,
                            input logic r);
    chk({tag, ".valid"}, o_sv, v);
    chk({tag, ".sout"},  o_so, b);
    chk({tag, ".start"}, o_fs, f);
    chk({tag, ".done"},  o_dn, d);
    chk({tag, ".ready"}, o_rdy, r);
  endtask

  task automatic send(input string tag,
                      input logic [7:0] w,
                      input bit busy);
    chk({tag, ".rdy0"}, o_rdy, 1'b1);
    drive(1'b1, w);
    tick();
    for (int k = 1; k <= FL; k++) begin
      expect_cyc($sformatf("%s.c%0d", tag, k), 1'b1,
                 ebit(w, k, !sel), k == 1, k == FL, k == FL);
      if (busy && k >= 2 && k <= 6) drive(1'b1, 8'h00);
      else drive(1'b0, 8'h00);
      tick();
    end
    expect_cyc({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b0;
    sel   = 1'b0;
    lv_m  = 1'b0;
    ld_m  = 8'h00;
    lv_l  = 1'b0;
    ld_l  = 8'h00;
    #12;
    expect_cyc("rst_m", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    sel = 1'b1;
    #1;
    expect_cyc("rst_l", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    sel   = 1'b0;
    reset = 1'b1;
    tick();

    send("msbA5", 8'hA5, 1'b0);
    tick();

    sel = 1'b1;
    send("lsb01", 8'h01, 1'b0);
    sel = 1'b0;
    tick();

    drive(1'b1, 8'hFF);
    tick();
    for (int k = 1; k <= 2 * FL; k++) begin
      logic [7:0] w;
      int kk;
      w  = (k <= FL) ? 8'hFF : 8'h01;
      kk = (k <= FL) ? k : k - FL;
      expect_cyc($sformatf("b2b.c%0d", k), 1'b1,
                 ebit(w, kk, 1'b1), kk == 1,
                 kk == FL, kk == FL);
      if (k <= FL) drive(1'b1, 8'h01);
      else drive(1'b0, 8'h00);
      tick();
    end
    expect_cyc("b2b.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    send("busyA5", 8'hA5, 1'b1);
    tick();

    drive(1'b1, 8'hFF);
    tick();
    drive(1'b0, 8'h00);
    for (int k = 1; k <= 3; k++) begin
      expect_cyc($sformatf("abort.c%0d", k), 1'b1, 1'b1,
                 k == 1, 1'b0, 1'b0);
      if (k < 3) tick();
    end
    reset = 1'b0;
    #1;
    expect_cyc("abort.rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    expect_cyc("abort.hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    reset = 1'b1;
    tick();
    expect_cyc("abort.post", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send("post80", 8'h80, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
